// File: rtl/dco_trim_pkg.sv
// dco_trim_pkg: shared types and helpers for the DCO trim sequencer.
//   state_e     - sequencer state (start-up hold, idle, slewing ramp)
//   cmax        - largest code for a given number of ring stages (2*stages)
//   code_width  - bits needed to hold codes 0..cmax
//   therm       - code to thermometer word, 'code' low bits set, limited to 'width' bits
package dco_trim_pkg;

  localparam int unsigned DefaultStages = 13;
  localparam int unsigned ThermMaxW     = 64;

  typedef enum logic [1:0] {
    StStart = 2'd0,
    StIdle  = 2'd1,
    StRamp  = 2'd2
  } state_e;

  function automatic int unsigned cmax(input int unsigned stages);
    return 2 * stages;
  endfunction

  function automatic int unsigned code_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

  localparam int unsigned DefaultCw = code_width(DefaultStages);

  function automatic logic [ThermMaxW-1:0] therm(input int unsigned code,
                                                 input int unsigned width);
    logic [ThermMaxW-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < ThermMaxW; i++) begin
      w[i] = (i < code) && (i < width);
    end
    return w;
  endfunction

endpackage

// File: rtl/dco_trim_sequencer_if.sv
// dco_trim_sequencer_if: target request handshake between the PLL loop controller
// (master) and the trim sequencer (slave).
//   target_code  - requested code (master -> slave)
//   target_valid - request strobe (master -> slave)
//   target_ready - sequencer accepts a request this cycle (slave -> master)
//   done         - one-cycle pulse, target reached (slave -> master)
//   target_sat   - one-cycle pulse, accepted target was clamped (slave -> master)
interface dco_trim_sequencer_if
  import dco_trim_pkg::*;
#(
  parameter int unsigned CW = DefaultCw
);
  logic [CW-1:0] target_code;
  logic          target_valid;
  logic          target_ready;
  logic          done;
  logic          target_sat;

  modport master (
    output target_code,
    output target_valid,
    input  target_ready,
    input  done,
    input  target_sat
  );

  modport slave (
    input  target_code,
    input  target_valid,
    output target_ready,
    output done,
    output target_sat
  );
endinterface

// File: rtl/dco_trim_therm.sv
// dco_trim_therm: binary code to thermometer trim encoder.
//   code       - in,  CW bits, number of trim bits to set (0..2*STAGES)
//   therm_word - out, 2*STAGES bits, bit i set when i < code; primaries [STAGES-1:0]
//                fill before secondaries [2*STAGES-1:STAGES]
module dco_trim_therm
  import dco_trim_pkg::*;
#(
  parameter int unsigned STAGES = DefaultStages,
  parameter int unsigned CW     = code_width(STAGES)
) (
  input  logic [CW-1:0]       code,
  output logic [2*STAGES-1:0] therm_word
);

  always_comb begin
    therm_word = '0;
    for (int unsigned i = 0; i < 2 * STAGES; i++) begin
      therm_word[i] = (CW'(i) < code);
    end
  end

endmodule

// File: rtl/dco_trim_sequencer.sv
// dco_trim_sequencer: trim controller for the ring-oscillator DCO.
// Holds the oscillator in reset for HOLD_CYCLES after enable, then accepts target codes,
// clamps them to 2*STAGES and slews the applied code one unit every STEP_DIV cycles so
// the thermometer trim word only ever changes by one bit. ext_sel bypasses the trim word
// with ext_trim and freezes the ramp.
// Build option: DCO_TRIM_RAMP_EN defined enables slewing; undefined applies an accepted
// target on the accepting edge (busy stays 0, STEP_DIV unused).
// Ports:
//   clock, resetb - clock, asynchronous active-low reset
//   enable        - oscillator enable, low forces the start-up hold
//   ext_sel       - 1 drives trim from ext_trim and pauses the sequencer
//   ext_trim      - raw external trim word
//   req           - target handshake (code/valid/ready/done/target_sat), slave side
//   trim          - trim word to the ring
//   cur_code      - code currently applied
//   osc_resetb    - oscillator reset, active low
//   busy          - ramp in progress
module dco_trim_sequencer
  import dco_trim_pkg::*;
#(
  parameter int unsigned STAGES      = DefaultStages,
  parameter int unsigned CW          = code_width(STAGES),
  parameter int unsigned STEP_DIV    = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned INIT_CODE   = 0
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                enable,
  input  logic                ext_sel,
  input  logic [2*STAGES-1:0] ext_trim,
  dco_trim_sequencer_if.slave req,
  output logic [2*STAGES-1:0] trim,
  output logic [CW-1:0]       cur_code,
  output logic                osc_resetb,
  output logic                busy
);

  localparam logic [CW-1:0] CmaxCode = CW'(cmax(STAGES));
  localparam logic [CW-1:0] InitCode = CW'(INIT_CODE);
  localparam int unsigned   HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  state_e             state_q;
  logic [CW-1:0]      cur_code_q;
  logic [HoldW-1:0]   hold_cnt_q;
  logic               osc_resetb_q;
  logic               busy_q;
  logic               done_q;
  logic               sat_q;
  logic               ready;
  logic               over;
  logic [CW-1:0]      clamped;
  logic [2*STAGES-1:0] therm_word;

`ifdef DCO_TRIM_RAMP_EN
  localparam int unsigned   StepW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_DIV - 1);

  logic [CW-1:0]    tgt_q;
  logic [StepW-1:0] step_cnt_q;
  logic [CW-1:0]    next_code;

  always_comb begin
    next_code = (tgt_q > cur_code_q) ? cur_code_q + 1'b1 : cur_code_q - 1'b1;
  end
`else
  logic unused_step_div;
  assign unused_step_div = (STEP_DIV == 0);
`endif

  always_comb begin
    over    = (req.target_code > CmaxCode);
    clamped = over ? CmaxCode : req.target_code;
  end

  assign ready = (state_q == StIdle) && !ext_sel;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= StStart;
      cur_code_q   <= InitCode;
      hold_cnt_q   <= '0;
      osc_resetb_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sat_q        <= 1'b0;
`ifdef DCO_TRIM_RAMP_EN
      tgt_q        <= InitCode;
      step_cnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      sat_q  <= 1'b0;
      if (!enable) begin
        // Code is kept so the oscillator restarts where it left off.
        state_q      <= StStart;
        hold_cnt_q   <= '0;
        osc_resetb_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        unique case (state_q)
          StStart: begin
            if (hold_cnt_q == HoldLast) begin
              state_q      <= StIdle;
              osc_resetb_q <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          StIdle: begin
            if (req.target_valid && ready) begin
              sat_q <= over;
              if (clamped == cur_code_q) begin
                done_q <= 1'b1;
              end else begin
`ifdef DCO_TRIM_RAMP_EN
                tgt_q      <= clamped;
                state_q    <= StRamp;
                step_cnt_q <= StepLast;
                busy_q     <= 1'b1;
`else
                cur_code_q <= clamped;
                done_q     <= 1'b1;
`endif
              end
            end
          end
`ifdef DCO_TRIM_RAMP_EN
          StRamp: begin
            // ext_sel freezes code and step counter so the ramp resumes seamlessly.
            if (!ext_sel) begin
              if (step_cnt_q == '0) begin
                step_cnt_q <= StepLast;
                cur_code_q <= next_code;
                if (next_code == tgt_q) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end else begin
                step_cnt_q <= step_cnt_q - 1'b1;
              end
            end
          end
`endif
          default: state_q <= StStart;
        endcase
      end
    end
  end

  dco_trim_therm #(
    .STAGES (STAGES),
    .CW     (CW)
  ) u_therm (
    .code       (cur_code_q),
    .therm_word (therm_word)
  );

  assign trim             = ext_sel ? ext_trim : therm_word;
  assign cur_code         = cur_code_q;
  assign osc_resetb       = osc_resetb_q;
  assign busy             = busy_q;
  assign req.target_ready = ready;
  assign req.done         = done_q;
  assign req.target_sat   = sat_q;

endmodule

// File: tb/tb_dco_trim_sequencer.sv
// tb_dco_trim_sequencer: self-checking bench for dco_trim_sequencer at default parameters.
// The reference model predicts the applied code from elapsed unpaused cycles since accept
// (code = start +/- cycles/STEP_DIV) and the trim word as (1<<code)-1.
// Follows DCO_TRIM_RAMP_EN like the design.
module tb_dco_trim_sequencer;
  localparam int unsigned STAGES      = 13;
  localparam int unsigned CW          = 5;
  localparam int unsigned STEP_DIV    = 4;
  localparam int unsigned HOLD_CYCLES = 8;
  localparam int unsigned INIT_CODE   = 0;
  localparam int unsigned CMAX        = 2 * STAGES;
  localparam int unsigned TW          = 2 * STAGES;

  logic          clock;
  logic          resetb;
  logic          enable;
  logic          ext_sel;
  logic [TW-1:0] ext_trim;
  logic [TW-1:0] trim;
  logic [CW-1:0] cur_code;
  logic          osc_resetb;
  logic          busy;

  int          n_checks;
  int          n_errors;
  int unsigned m_code;
  bit          ramp_mode;

  dco_trim_sequencer_if #(.CW(CW)) bus ();

  dco_trim_sequencer #(
    .STAGES      (STAGES),
    .CW          (CW),
    .STEP_DIV    (STEP_DIV),
    .HOLD_CYCLES (HOLD_CYCLES),
    .INIT_CODE   (INIT_CODE)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .enable     (enable),
    .ext_sel    (ext_sel),
    .ext_trim   (ext_trim),
    .req        (bus),
    .trim       (trim),
    .cur_code   (cur_code),
    .osc_resetb (osc_resetb),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [TW-1:0] therm_model(input int unsigned code);
    logic [63:0] v;
    v = (64'd1 << code) - 64'd1;
    return v[TW-1:0];
  endfunction

  // Asynchronous reset, reset values (incl. bypass), then the start-up hold.
  task automatic test_reset();
    logic [TW-1:0] w;
    w = TW'($urandom);
    resetb = 1'b0; enable = 1'b1; ext_sel = 1'b1; ext_trim = w; bus.target_valid = 1'b0;
    #2;
    n_checks++; if (trim !== w) begin n_errors++; $display("FAIL reset_trim_ext: got %h want %h", trim, w); end
    ext_sel = 1'b0;
    #1;
    n_checks++; if (trim !== therm_model(INIT_CODE)) begin n_errors++; $display("FAIL reset_trim: got %h want %h", trim, therm_model(INIT_CODE)); end
    n_checks++; if (cur_code !== CW'(INIT_CODE)) begin n_errors++; $display("FAIL reset_code: got %0d want %0d", cur_code, INIT_CODE); end
    n_checks++; if (osc_resetb !== 1'b0) begin n_errors++; $display("FAIL reset_osc: got %b want 0", osc_resetb); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.target_sat !== 1'b0) begin n_errors++; $display("FAIL reset_sat: got %b want 0", bus.target_sat); end
    n_checks++; if (bus.target_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", bus.target_ready); end
    @(negedge clock);
    resetb = 1'b1;
    for (int i = 1; i <= int'(HOLD_CYCLES); i++) begin
      @(posedge clock); #1;
      n_checks++; if (osc_resetb !== (i == int'(HOLD_CYCLES))) begin n_errors++; $display("FAIL startup_osc edge %0d: got %b want %b", i, osc_resetb, i == int'(HOLD_CYCLES)); end
      n_checks++; if (bus.target_ready !== (i == int'(HOLD_CYCLES))) begin n_errors++; $display("FAIL startup_ready edge %0d: got %b", i, bus.target_ready); end
    end
    m_code = INIT_CODE;
  endtask

  // Request a code and follow the ramp, optionally pausing it with ext_sel for
  // pause_len cycles once pause_start unpaused cycles have elapsed since accept.
  task automatic move_to(input int unsigned req_code, input int unsigned pause_start,
                         input int unsigned pause_len, input logic [TW-1:0] ext_word);
    int unsigned clamped, delta, total, active, paused, guard, exp_code;
    bit up, sat, ext_now;
    logic [TW-1:0] prev_trim, exp_trim;
    clamped = (req_code > CMAX) ? CMAX : req_code;
    sat     = (req_code > CMAX);
    up      = (clamped >= m_code);
    delta   = up ? clamped - m_code : m_code - clamped;
    total   = ramp_mode ? delta * STEP_DIV : 0;
    bus.target_code = CW'(req_code); bus.target_valid = 1'b1;
    @(posedge clock); #1;
    bus.target_valid = 1'b0; bus.target_code = CW'($urandom);
    exp_code = ramp_mode ? m_code : clamped;
    n_checks++; if (bus.target_sat !== sat) begin n_errors++; $display("FAIL accept_sat req %0d: got %b want %b", req_code, bus.target_sat, sat); end
    n_checks++; if (cur_code !== CW'(exp_code)) begin n_errors++; $display("FAIL accept_code req %0d: got %0d want %0d", req_code, cur_code, exp_code); end
    n_checks++; if (trim !== therm_model(exp_code)) begin n_errors++; $display("FAIL accept_trim req %0d: got %h want %h", req_code, trim, therm_model(exp_code)); end
    n_checks++; if (bus.done !== (total == 0)) begin n_errors++; $display("FAIL accept_done req %0d: got %b want %b", req_code, bus.done, total == 0); end
    n_checks++; if (busy !== (total != 0)) begin n_errors++; $display("FAIL accept_busy req %0d: got %b want %b", req_code, busy, total != 0); end
    n_checks++; if (bus.target_ready !== (total == 0)) begin n_errors++; $display("FAIL accept_ready req %0d: got %b", req_code, bus.target_ready); end
    prev_trim = trim;
    active = 0; paused = 0; guard = 0;
    while (active < total && guard < 2000) begin
      ext_now  = (pause_len > 0) && (active == pause_start) && (paused < pause_len);
      ext_sel  = ext_now;
      ext_trim = ext_word;
      @(posedge clock); #1;
      guard++;
      if (ext_now) paused++; else active++;
      exp_code = up ? m_code + active / STEP_DIV : m_code - active / STEP_DIV;
      exp_trim = ext_now ? ext_word : therm_model(exp_code);
      n_checks++; if (cur_code !== CW'(exp_code)) begin n_errors++; $display("FAIL ramp_code cyc %0d: got %0d want %0d", guard, cur_code, exp_code); end
      n_checks++; if (trim !== exp_trim) begin n_errors++; $display("FAIL ramp_trim cyc %0d: got %h want %h", guard, trim, exp_trim); end
      n_checks++; if (busy !== (active < total)) begin n_errors++; $display("FAIL ramp_busy cyc %0d: got %b", guard, busy); end
      n_checks++; if (bus.done !== (!ext_now && active == total)) begin n_errors++; $display("FAIL ramp_done cyc %0d: got %b", guard, bus.done); end
      n_checks++; if (bus.target_ready !== (!ext_now && active == total)) begin n_errors++; $display("FAIL ramp_ready cyc %0d: got %b", guard, bus.target_ready); end
      n_checks++; if (bus.target_sat !== 1'b0) begin n_errors++; $display("FAIL ramp_sat cyc %0d: got %b want 0", guard, bus.target_sat); end
      if (!ext_now) begin
        n_checks++; if ($countones(trim ^ prev_trim) > 1) begin n_errors++; $display("FAIL ramp_one_bit cyc %0d: %h -> %h", guard, prev_trim, trim); end
        prev_trim = trim;
      end
    end
    ext_sel = 1'b0;
    if (active < total) begin
      n_checks++; n_errors++;
      $display("FAIL ramp_timeout: reached %0d of %0d cycles", active, total);
    end
    @(posedge clock); #1;
    n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL after_done: got %b want 0", bus.done); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL after_busy: got %b want 0", busy); end
    n_checks++; if (bus.target_ready !== 1'b1) begin n_errors++; $display("FAIL after_ready: got %b want 1", bus.target_ready); end
    n_checks++; if (cur_code !== CW'(clamped)) begin n_errors++; $display("FAIL after_code: got %0d want %0d", cur_code, clamped); end
    m_code = clamped;
  endtask

  task automatic test_ramp_up();
    move_to(5, 999, 0, '0);
  endtask

  task automatic test_clamp_ramp_down();
    move_to(26, 999, 0, '0);
    move_to(30, 999, 0, '0);
    move_to(12, 999, 0, '0);
  endtask

  task automatic test_bypass_mid_ramp();
    move_to(0, 999, 0, '0);
    move_to(10, 3 * STEP_DIV, 6, TW'($urandom));
  endtask

  // A request held during bypass must not be taken, and no trailing accept on release.
  task automatic test_bypass_blocks();
    logic [TW-1:0] w;
    w = TW'($urandom);
    ext_sel = 1'b1; ext_trim = w;
    bus.target_code = CW'((m_code + 7) % (CMAX + 1)); bus.target_valid = 1'b1;
    #1;
    n_checks++; if (bus.target_ready !== 1'b0) begin n_errors++; $display("FAIL bypass_ready: got %b want 0", bus.target_ready); end
    n_checks++; if (trim !== w) begin n_errors++; $display("FAIL bypass_trim: got %h want %h", trim, w); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      n_checks++; if (cur_code !== CW'(m_code)) begin n_errors++; $display("FAIL bypass_code: got %0d want %0d", cur_code, m_code); end
      n_checks++; if (bus.done !== 1'b0 || bus.target_sat !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL bypass_flags: done %b sat %b busy %b want 000", bus.done, bus.target_sat, busy); end
    end
    ext_sel = 1'b0; bus.target_valid = 1'b0;
    #1;
    n_checks++; if (bus.target_ready !== 1'b1) begin n_errors++; $display("FAIL bypass_release_ready: got %b want 1", bus.target_ready); end
    n_checks++; if (trim !== therm_model(m_code)) begin n_errors++; $display("FAIL bypass_release_trim: got %h want %h", trim, therm_model(m_code)); end
  endtask

  task automatic test_random_moves();
    for (int i = 0; i < 8; i++) begin
      move_to($urandom_range(0, 31), $urandom_range(0, 40), $urandom_range(0, 4), TW'($urandom));
    end
  endtask

  // enable low mid-ramp: hold restarts, code retained.
  task automatic test_enable_low();
    int unsigned req_code, clamped, delta, exp_code;
    bit up;
    req_code = (m_code == 20) ? 4 : 20;
    clamped  = req_code;
    up       = (clamped >= m_code);
    delta    = up ? clamped - m_code : m_code - clamped;
    bus.target_code = CW'(req_code); bus.target_valid = 1'b1;
    @(posedge clock); #1;
    bus.target_valid = 1'b0;
    repeat (8) begin @(posedge clock); #1; end
    if (!ramp_mode) exp_code = clamped;
    else if (8 / STEP_DIV >= delta) exp_code = clamped;
    else exp_code = up ? m_code + 8 / STEP_DIV : m_code - 8 / STEP_DIV;
    enable = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (osc_resetb !== 1'b0) begin n_errors++; $display("FAIL enlow_osc: got %b want 0", osc_resetb); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL enlow_busy: got %b want 0", busy); end
    n_checks++; if (bus.target_ready !== 1'b0) begin n_errors++; $display("FAIL enlow_ready: got %b want 0", bus.target_ready); end
    n_checks++; if (cur_code !== CW'(exp_code)) begin n_errors++; $display("FAIL enlow_code: got %0d want %0d", cur_code, exp_code); end
    repeat (3) begin @(posedge clock); #1; end
    n_checks++; if (cur_code !== CW'(exp_code)) begin n_errors++; $display("FAIL enlow_code_held: got %0d want %0d", cur_code, exp_code); end
    enable = 1'b1;
    for (int i = 1; i <= int'(HOLD_CYCLES); i++) begin
      @(posedge clock); #1;
      n_checks++; if (osc_resetb !== (i == int'(HOLD_CYCLES))) begin n_errors++; $display("FAIL rehold_osc edge %0d: got %b", i, osc_resetb); end
      n_checks++; if (cur_code !== CW'(exp_code)) begin n_errors++; $display("FAIL rehold_code edge %0d: got %0d want %0d", i, cur_code, exp_code); end
    end
    m_code = exp_code;
  endtask

  // resetb pulse mid-ramp returns the code to INIT_CODE.
  task automatic test_reset_pulse();
    bus.target_code = CW'((m_code == 24) ? 2 : 24); bus.target_valid = 1'b1;
    @(posedge clock); #1;
    bus.target_valid = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    #2;
    test_reset();
    move_to(3, 999, 0, '0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; m_code = INIT_CODE;
`ifdef DCO_TRIM_RAMP_EN
    ramp_mode = 1'b1;
`else
    ramp_mode = 1'b0;
`endif
    resetb = 1'b0; enable = 1'b1; ext_sel = 1'b0; ext_trim = '0;
    bus.target_code = '0; bus.target_valid = 1'b0;
    test_reset();
    test_ramp_up();
    test_clamp_ramp_down();
    test_bypass_mid_ramp();
    test_bypass_blocks();
    test_random_moves();
    test_enable_low();
    test_reset_pulse();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
